// File: rtl/alu_scheduler_pkg.sv
// alu_scheduler_pkg: shared widths, ALU opcodes and scheduler state encodings.
package alu_scheduler_pkg;

    localparam int DATA_WIDTH = 16;

    localparam logic [DATA_WIDTH-1:0] ALU_COMPARER = 16'h0001;
    localparam logic [DATA_WIDTH-1:0] ALU_JUMP_CON = 16'h0002;

    typedef enum logic [1:0] {
        ALU_SCHED_IDLE = 2'd0,
        ALU_SCHED_EXEC = 2'd1,
        ALU_SCHED_RESP = 2'd2
    } sched_state_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] cfg;
        logic [DATA_WIDTH-1:0] op0;
        logic [DATA_WIDTH-1:0] op1;
        logic [DATA_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] pc;
    } req_fields_t;

endpackage

// File: rtl/alu_scheduler_if.sv
// alu_scheduler_if: both clients' request/response handshakes plus the ALU-facing bus.
interface alu_scheduler_if;
    import alu_scheduler_pkg::*;

    logic                  i_req0_valid;
    logic                  i_req1_valid;
    logic                  o_req0_ready;
    logic                  o_req1_ready;
    logic [DATA_WIDTH-1:0] i_req0_config;
    logic [DATA_WIDTH-1:0] i_req0_operand0;
    logic [DATA_WIDTH-1:0] i_req0_operand1;
    logic [DATA_WIDTH-1:0] i_req0_address;
    logic [DATA_WIDTH-1:0] i_req0_pc;
    logic [DATA_WIDTH-1:0] i_req1_config;
    logic [DATA_WIDTH-1:0] i_req1_operand0;
    logic [DATA_WIDTH-1:0] i_req1_operand1;
    logic [DATA_WIDTH-1:0] i_req1_address;
    logic [DATA_WIDTH-1:0] i_req1_pc;
    logic                  o_rsp0_valid;
    logic                  o_rsp1_valid;
    logic                  i_rsp0_ready;
    logic                  i_rsp1_ready;
    logic [DATA_WIDTH-1:0] o_rsp_data;
    logic                  o_alu_re_oen;
    logic                  o_alu_ad_oen;
    logic [DATA_WIDTH-1:0] o_alu_config;
    logic [DATA_WIDTH-1:0] o_alu_operand0;
    logic [DATA_WIDTH-1:0] o_alu_operand1;
    logic [DATA_WIDTH-1:0] o_alu_address_reg;
    logic [DATA_WIDTH-1:0] o_alu_program_count;
    logic [DATA_WIDTH-1:0] i_alu_output;
    logic                  o_busy;

    modport slave (
        input  i_req0_valid, i_req1_valid,
        input  i_req0_config, i_req0_operand0, i_req0_operand1, i_req0_address, i_req0_pc,
        input  i_req1_config, i_req1_operand0, i_req1_operand1, i_req1_address, i_req1_pc,
        input  i_rsp0_ready, i_rsp1_ready, i_alu_output,
        output o_req0_ready, o_req1_ready, o_rsp0_valid, o_rsp1_valid, o_rsp_data,
        output o_alu_re_oen, o_alu_ad_oen, o_alu_config, o_alu_operand0, o_alu_operand1,
        output o_alu_address_reg, o_alu_program_count, o_busy
    );

    modport master (
        output i_req0_valid, i_req1_valid,
        output i_req0_config, i_req0_operand0, i_req0_operand1, i_req0_address, i_req0_pc,
        output i_req1_config, i_req1_operand0, i_req1_operand1, i_req1_address, i_req1_pc,
        output i_rsp0_ready, i_rsp1_ready, i_alu_output,
        input  o_req0_ready, o_req1_ready, o_rsp0_valid, o_rsp1_valid, o_rsp_data,
        input  o_alu_re_oen, o_alu_ad_oen, o_alu_config, o_alu_operand0, o_alu_operand1,
        input  o_alu_address_reg, o_alu_program_count, o_busy
    );

endinterface

// File: rtl/alu_sched_arbiter.sv
// alu_sched_arbiter: 2-way one-hot grant from the request valids and the fairness pointer.
// Define ALU_SCHED_FIXED_PRIO_EN to drop the pointer and always favour client 0.
module alu_sched_arbiter (
    input  logic       valid0_i,
    input  logic       valid1_i,
`ifndef ALU_SCHED_FIXED_PRIO_EN
    input  logic       ptr_i,
`endif
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
`ifdef ALU_SCHED_FIXED_PRIO_EN
        if (valid0_i) begin
            grant_o = 2'b01;
        end else if (valid1_i) begin
            grant_o = 2'b10;
        end
`else
        // The pointer only matters when both clients compete.
        if (valid0_i && valid1_i) begin
            grant_o = ptr_i ? 2'b10 : 2'b01;
        end else if (valid0_i) begin
            grant_o = 2'b01;
        end else if (valid1_i) begin
            grant_o = 2'b10;
        end
`endif
    end

endmodule

// File: rtl/alu_scheduler.sv
// alu_scheduler: grants the shared ALU to one of two clients, waits its latency, returns the result.
// Define ALU_SCHED_FIXED_PRIO_EN for fixed client-0 priority instead of round-robin.
module alu_scheduler
    import alu_scheduler_pkg::*;
#(
    parameter int ALU_LATENCY = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_scheduler_if.slave bus
);

    localparam logic [2:0] LATENCY_CNT = 3'(ALU_LATENCY);

    sched_state_e          state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  owner_q, owner_d;
    req_fields_t           fields_q, fields_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic [1:0]            grant;
    logic                  rsp_ready;
    logic                  exec;
    req_fields_t           req0, req1;
`ifndef ALU_SCHED_FIXED_PRIO_EN
    logic                  ptr_q, ptr_d;
`endif

    assign req0 = '{cfg: bus.i_req0_config, op0: bus.i_req0_operand0, op1: bus.i_req0_operand1,
                    addr: bus.i_req0_address, pc: bus.i_req0_pc};
    assign req1 = '{cfg: bus.i_req1_config, op0: bus.i_req1_operand0, op1: bus.i_req1_operand1,
                    addr: bus.i_req1_address, pc: bus.i_req1_pc};

    alu_sched_arbiter u_arbiter (
        .valid0_i (bus.i_req0_valid),
        .valid1_i (bus.i_req1_valid),
`ifndef ALU_SCHED_FIXED_PRIO_EN
        .ptr_i    (ptr_q),
`endif
        .grant_o  (grant)
    );

    assign rsp_ready = owner_q ? bus.i_rsp1_ready : bus.i_rsp0_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ALU_SCHED_IDLE;
            cnt_q    <= '0;
            owner_q  <= 1'b0;
            fields_q <= '0;
            result_q <= '0;
`ifndef ALU_SCHED_FIXED_PRIO_EN
            ptr_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            owner_q  <= owner_d;
            fields_q <= fields_d;
            result_q <= result_d;
`ifndef ALU_SCHED_FIXED_PRIO_EN
            ptr_q    <= ptr_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        owner_d  = owner_q;
        fields_d = fields_q;
        result_d = result_q;
`ifndef ALU_SCHED_FIXED_PRIO_EN
        ptr_d    = ptr_q;
`endif
        case (state_q)
            ALU_SCHED_IDLE: begin
                if (grant != 2'b00) begin
                    owner_d  = grant[1];
                    fields_d = grant[1] ? req1 : req0;
                    cnt_d    = LATENCY_CNT;
                    state_d  = ALU_SCHED_EXEC;
                end
            end
            ALU_SCHED_EXEC: begin
                // The ALU has seen stable inputs for the full latency once the count runs out.
                if (cnt_q == 3'd0) begin
                    result_d = bus.i_alu_output;
                    state_d  = ALU_SCHED_RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ALU_SCHED_RESP: begin
                if (rsp_ready) begin
                    state_d = ALU_SCHED_IDLE;
`ifndef ALU_SCHED_FIXED_PRIO_EN
                    ptr_d   = ~owner_q;
`endif
                end
            end
            default: state_d = ALU_SCHED_IDLE;
        endcase
    end

    assign exec = (state_q == ALU_SCHED_EXEC);

    assign bus.o_req0_ready        = (state_q == ALU_SCHED_IDLE) && grant[0];
    assign bus.o_req1_ready        = (state_q == ALU_SCHED_IDLE) && grant[1];
    assign bus.o_rsp0_valid        = (state_q == ALU_SCHED_RESP) && !owner_q;
    assign bus.o_rsp1_valid        = (state_q == ALU_SCHED_RESP) && owner_q;
    assign bus.o_rsp_data          = result_q;
    assign bus.o_busy              = (state_q != ALU_SCHED_IDLE);
    assign bus.o_alu_re_oen        = exec;
    assign bus.o_alu_ad_oen        = 1'b0;
    assign bus.o_alu_config        = exec ? fields_q.cfg  : '0;
    assign bus.o_alu_operand0      = exec ? fields_q.op0  : '0;
    assign bus.o_alu_operand1      = exec ? fields_q.op1  : '0;
    assign bus.o_alu_address_reg   = exec ? fields_q.addr : '0;
    assign bus.o_alu_program_count = exec ? fields_q.pc   : '0;

endmodule

// File: tb/tb_alu_scheduler.sv
// tb_alu_scheduler: directed vectors, multi-cycle corner sequences and a randomized run
// against a transaction-level model of the scheduler (XOR ALU model, latencies 1 and 4).
module tb_alu_scheduler;
    import alu_scheduler_pkg::*;

    typedef struct {
        int                    client;
        logic [DATA_WIDTH-1:0] cfg;
        logic [DATA_WIDTH-1:0] op0;
        logic [DATA_WIDTH-1:0] op1;
        logic [DATA_WIDTH-1:0] exp;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    vec_t                  vecs[5];
    int                    t0, winner, reCount, firstRsp, lastServed, owner, acceptCyc;
    bit                    got, busy, sawRsp;
    bit                    pend[2];
    logic [DATA_WIDTH-1:0] rcfg[2], rop0[2], rop1[2];
    logic [DATA_WIDTH-1:0] expData, held;
    logic [1:0]            expReady, expRsp;

    alu_scheduler_if ifa();
    alu_scheduler_if ifb();

    alu_scheduler #(.ALU_LATENCY(1)) dut  (.clk(clk), .rst_n(rst_n), .bus(ifa));
    alu_scheduler #(.ALU_LATENCY(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(ifb));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign ifa.i_alu_output = ifa.o_alu_re_oen ? (ifa.o_alu_operand0 ^ ifa.o_alu_operand1) : '0;
    assign ifb.i_alu_output = ifb.o_alu_re_oen ? (ifb.o_alu_operand0 ^ ifb.o_alu_operand1) : '0;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input int c, input logic v, input logic [DATA_WIDTH-1:0] cfg,
                                 input logic [DATA_WIDTH-1:0] op0, input logic [DATA_WIDTH-1:0] op1);
        if (c == 0) begin
            ifa.i_req0_valid    = v;
            ifa.i_req0_config   = cfg;
            ifa.i_req0_operand0 = op0;
            ifa.i_req0_operand1 = op1;
            ifa.i_req0_address  = op0 + 16'h0100;
            ifa.i_req0_pc       = op1 - 16'h0001;
        end else begin
            ifa.i_req1_valid    = v;
            ifa.i_req1_config   = cfg;
            ifa.i_req1_operand0 = op0;
            ifa.i_req1_operand1 = op1;
            ifa.i_req1_address  = op0 + 16'h0100;
            ifa.i_req1_pc       = op1 - 16'h0001;
        end
    endtask

    function automatic logic readyOf(input int c);
        return (c == 0) ? ifa.o_req0_ready : ifa.o_req1_ready;
    endfunction

    function automatic logic rspValidOf(input int c);
        return (c == 0) ? ifa.o_rsp0_valid : ifa.o_rsp1_valid;
    endfunction

    task automatic toDrive();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        toDrive();
        rst_n = 1'b0;
        applyStimulus(0, 1'b0, '0, '0, '0);
        applyStimulus(1, 1'b0, '0, '0, '0);
        ifa.i_rsp0_ready = 1'b0;
        ifa.i_rsp1_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic waitIdle(input string name);
        bit idle;
        idle = 1'b0;
        for (int k = 0; k < 20 && !idle; k++) begin
            @(negedge clk);
            if (!ifa.o_busy) idle = 1'b1;
        end
        checkOutput(name, 32'(idle), 32'd1);
    endtask

    // One isolated request on the latency-1 scheduler with an always-ready consumer.
    task automatic doTransaction(input int c, input logic [DATA_WIDTH-1:0] cfg, input logic [DATA_WIDTH-1:0] op0,
                                 input logic [DATA_WIDTH-1:0] op1, input logic [DATA_WIDTH-1:0] exp);
        bit seen;
        int tAcc;
        ifa.i_rsp0_ready = 1'b1;
        ifa.i_rsp1_ready = 1'b1;
        toDrive();
        applyStimulus(c, 1'b1, cfg, op0, op1);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (readyOf(c)) seen = 1'b1;
        end
        checkOutput("accept", 32'(seen), 32'd1);
        tAcc = cyc;
        toDrive();
        applyStimulus(c, 1'b0, cfg, op0, op1);
        @(negedge clk);
        checkOutput("alu_config_fwd", 32'(ifa.o_alu_config), 32'(cfg));
        checkOutput("alu_operand0", 32'(ifa.o_alu_operand0), 32'(op0));
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (rspValidOf(c)) seen = 1'b1;
            else @(negedge clk);
        end
        checkOutput("rsp_seen", 32'(seen), 32'd1);
        checkOutput("rsp_latency", 32'(cyc - tAcc), 32'd3);
        checkOutput("rsp_data", 32'(ifa.o_rsp_data), 32'(exp));
        checkOutput("rsp_other_quiet", 32'(rspValidOf(1 - c)), 32'd0);
        @(negedge clk);
        checkOutput("idle_after_rsp", 32'(ifa.o_busy), 32'd0);
    endtask

    initial begin
        applyStimulus(0, 1'b0, '0, '0, '0);
        applyStimulus(1, 1'b0, '0, '0, '0);
        ifa.i_rsp0_ready = 1'b0;
        ifa.i_rsp1_ready = 1'b0;
        ifb.i_req0_valid = 1'b0; ifb.i_req0_config = '0; ifb.i_req0_operand0 = '0;
        ifb.i_req0_operand1 = '0; ifb.i_req0_address = '0; ifb.i_req0_pc = '0;
        ifb.i_req1_valid = 1'b0; ifb.i_req1_config = '0; ifb.i_req1_operand0 = '0;
        ifb.i_req1_operand1 = '0; ifb.i_req1_address = '0; ifb.i_req1_pc = '0;
        ifb.i_rsp0_ready = 1'b0;
        ifb.i_rsp1_ready = 1'b0;

        vecs[0] = '{0, ALU_COMPARER, 16'h000F, 16'h00F0, 16'h00FF};
        vecs[1] = '{1, ALU_JUMP_CON, 16'h1234, 16'h00FF, 16'h12CB};
        vecs[2] = '{0, 16'hFFFF,     16'hAAAA, 16'h5555, 16'hFFFF};
        vecs[3] = '{1, 16'hFFFF,     16'hFFFF, 16'hFFFF, 16'h0000};
        vecs[4] = '{0, ALU_COMPARER, 16'h8001, 16'h8000, 16'h0001};

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_busy", 32'(ifa.o_busy), 32'd0);
        checkOutput("rst_re_oen", 32'(ifa.o_alu_re_oen), 32'd0);
        checkOutput("rst_rsp_valid", 32'({ifa.o_rsp1_valid, ifa.o_rsp0_valid}), 32'd0);
        checkOutput("rst_rsp_data", 32'(ifa.o_rsp_data), 32'd0);
        checkOutput("rst_operand0", 32'(ifa.o_alu_operand0), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle_ready", 32'({ifa.o_req1_ready, ifa.o_req0_ready}), 32'd0);

        for (int i = 0; i < 5; i++) begin
            doTransaction(vecs[i].client, vecs[i].cfg, vecs[i].op0, vecs[i].op1, vecs[i].exp);
        end

        // Contention: both clients request continuously from a fresh pointer.
        doReset();
        ifa.i_rsp0_ready = 1'b1;
        ifa.i_rsp1_ready = 1'b1;
        toDrive();
        applyStimulus(0, 1'b1, ALU_COMPARER, 16'h0100, 16'h0001);
        applyStimulus(1, 1'b1, ALU_COMPARER, 16'h0200, 16'h0002);
        for (int g = 0; g < 4; g++) begin
            got    = 1'b0;
            winner = -1;
            for (int k = 0; k < 20 && !got; k++) begin
                @(negedge clk);
                if (ifa.o_req0_ready || ifa.o_req1_ready) begin
                    got    = 1'b1;
                    winner = ifa.o_req1_ready ? 1 : 0;
                    checkOutput("rr_onehot", 32'(ifa.o_req0_ready & ifa.o_req1_ready), 32'd0);
                end
            end
`ifdef ALU_SCHED_FIXED_PRIO_EN
            checkOutput("rr_grant", 32'(winner), 32'd0);
`else
            checkOutput("rr_grant", 32'(winner), 32'(g % 2));
`endif
            toDrive();
            if (winner >= 0) applyStimulus(winner, 1'b1, ALU_COMPARER, 16'(g * 16), 16'(g + 3));
        end
        toDrive();
        applyStimulus(0, 1'b0, '0, '0, '0);
        applyStimulus(1, 1'b0, '0, '0, '0);
        waitIdle("rr_drain");

        // Backpressure on client 1 while client 0 waits.
        ifa.i_rsp0_ready = 1'b1;
        ifa.i_rsp1_ready = 1'b0;
        toDrive();
        applyStimulus(1, 1'b1, ALU_JUMP_CON, 16'h0F0F, 16'h00FF);
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (ifa.o_req1_ready) got = 1'b1;
        end
        checkOutput("bp_accept1", 32'(got), 32'd1);
        toDrive();
        applyStimulus(1, 1'b0, ALU_JUMP_CON, 16'h0F0F, 16'h00FF);
        applyStimulus(0, 1'b1, ALU_COMPARER, 16'h3333, 16'h1111);
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (ifa.o_rsp1_valid) got = 1'b1;
            else checkOutput("bp_no_ready0_exec", 32'(ifa.o_req0_ready), 32'd0);
        end
        checkOutput("bp_rsp1_seen", 32'(got), 32'd1);
        for (int k = 0; k < 5; k++) begin
            checkOutput("bp_rsp1_held", 32'(ifa.o_rsp1_valid), 32'd1);
            checkOutput("bp_data_held", 32'(ifa.o_rsp_data), 32'h0FF0);
            checkOutput("bp_ready0_low", 32'(ifa.o_req0_ready), 32'd0);
            @(negedge clk);
        end
        toDrive();
        ifa.i_rsp1_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_hs_cycle_ready0", 32'(ifa.o_req0_ready), 32'd0);
        @(negedge clk);
        checkOutput("bp_next_accept", 32'(ifa.o_req0_ready), 32'd1);
        checkOutput("bp_rsp1_gone", 32'(ifa.o_rsp1_valid), 32'd0);
        toDrive();
        applyStimulus(0, 1'b0, ALU_COMPARER, 16'h3333, 16'h1111);
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (ifa.o_rsp0_valid) got = 1'b1;
        end
        checkOutput("bp_rsp0_data", 32'(ifa.o_rsp_data), 32'h2222);
        waitIdle("bp_drain");

        // Asynchronous reset while the ALU is being driven.
        ifa.i_rsp0_ready = 1'b1;
        toDrive();
        applyStimulus(0, 1'b1, ALU_COMPARER, 16'h00AA, 16'h0055);
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (ifa.o_req0_ready) got = 1'b1;
        end
        toDrive();
        applyStimulus(0, 1'b0, ALU_COMPARER, 16'h00AA, 16'h0055);
        checkOutput("mid_exec_re_oen", 32'(ifa.o_alu_re_oen), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_busy", 32'(ifa.o_busy), 32'd0);
        checkOutput("arst_re_oen", 32'(ifa.o_alu_re_oen), 32'd0);
        checkOutput("arst_operand0", 32'(ifa.o_alu_operand0), 32'd0);
        checkOutput("arst_config", 32'(ifa.o_alu_config), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sawRsp = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (ifa.o_rsp0_valid || ifa.o_rsp1_valid || ifa.o_busy) sawRsp = 1'b1;
        end
        checkOutput("arst_no_rsp", 32'(sawRsp), 32'd0);
        doTransaction(0, ALU_COMPARER, 16'h0F00, 16'h00F0, 16'h0FF0);

        // Latency-4 scheduler: jump op from client 1.
        ifb.i_rsp1_ready = 1'b1;
        toDrive();
        ifb.i_req1_valid    = 1'b1;
        ifb.i_req1_config   = ALU_JUMP_CON;
        ifb.i_req1_operand0 = 16'h1000;
        ifb.i_req1_operand1 = 16'h0234;
        ifb.i_req1_address  = 16'h4000;
        ifb.i_req1_pc       = 16'h0040;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (ifb.o_req1_ready) got = 1'b1;
        end
        checkOutput("l4_accept", 32'(got), 32'd1);
        t0 = cyc;
        toDrive();
        ifb.i_req1_valid = 1'b0;
        reCount  = 0;
        firstRsp = -1;
        held     = '0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 0) begin
                checkOutput("l4_address", 32'(ifb.o_alu_address_reg), 32'h4000);
                checkOutput("l4_pc", 32'(ifb.o_alu_program_count), 32'h0040);
                checkOutput("l4_ad_oen", 32'(ifb.o_alu_ad_oen), 32'd0);
            end
            if (ifb.o_alu_re_oen) reCount++;
            if (ifb.o_rsp1_valid && firstRsp < 0) begin
                firstRsp = cyc;
                held     = ifb.o_rsp_data;
            end
        end
        checkOutput("l4_re_oen_cycles", 32'(reCount), 32'd5);
        checkOutput("l4_rsp_latency", 32'(firstRsp - t0), 32'd6);
        checkOutput("l4_rsp_data", 32'(held), 32'h1234);
        checkOutput("l4_idle", 32'(ifb.o_busy), 32'd0);

        // Randomized run against the transaction-level model.
        doReset();
        pend[0]    = 1'b0;
        pend[1]    = 1'b0;
        busy       = 1'b0;
        owner      = 0;
        lastServed = 1;
        acceptCyc  = 0;
        expData    = '0;
        for (int i = 0; i < 1500; i++) begin
            toDrive();
            for (int c = 0; c < 2; c++) begin
                if (!pend[c] && $urandom_range(0, 2) == 0) begin
                    pend[c] = 1'b1;
                    rcfg[c] = 16'($urandom);
                    rop0[c] = 16'($urandom);
                    rop1[c] = 16'($urandom);
                end
                applyStimulus(c, pend[c], rcfg[c], rop0[c], rop1[c]);
            end
            ifa.i_rsp0_ready = 1'($urandom_range(0, 1));
            ifa.i_rsp1_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            expReady = 2'b00;
            winner   = -1;
            if (!busy && (pend[0] || pend[1])) begin
                if (pend[0] && pend[1]) begin
`ifdef ALU_SCHED_FIXED_PRIO_EN
                    winner = 0;
`else
                    winner = (lastServed == 0) ? 1 : 0;
`endif
                end else begin
                    winner = pend[0] ? 0 : 1;
                end
                expReady[winner] = 1'b1;
            end
            expRsp = 2'b00;
            if (busy && cyc >= acceptCyc + 3) expRsp[owner] = 1'b1;
            checkOutput("rnd_ready", 32'({ifa.o_req1_ready, ifa.o_req0_ready}), 32'(expReady));
            checkOutput("rnd_rsp_valid", 32'({ifa.o_rsp1_valid, ifa.o_rsp0_valid}), 32'(expRsp));
            if (expRsp != 2'b00) checkOutput("rnd_rsp_data", 32'(ifa.o_rsp_data), 32'(expData));
            if (expRsp != 2'b00 && ((owner == 0) ? ifa.i_rsp0_ready : ifa.i_rsp1_ready)) begin
                busy       = 1'b0;
                lastServed = owner;
            end else if (winner >= 0) begin
                busy         = 1'b1;
                owner        = winner;
                expData      = rop0[winner] ^ rop1[winner];
                acceptCyc    = cyc;
                pend[winner] = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
